ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives PS/2 keyboard frames (scan-code set 2), validates them, and turns make codes into the single-cycle key events consumed by the calculator `control` block. The outputs are `dig_in`, `op_in`, `bksp_in` and `keycode`. The block sits directly upstream of `control` and drives its event inputs. It filters break (key-release) codes and unsupported keys, so `control` only ever sees one pulse per key press.

## Interface
- `TIMEOUT_CYCLES`, 50000: `clock` cycles without a PS/2 falling edge after which a partial frame is abandoned (1 ms at 50 MHz).
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pad, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pad, asynchronous.
- `dig_in`  out  1  one-cycle pulse: digit key pressed.
- `op_in`  out  1  one-cycle pulse: operator key pressed.
- `bksp_in`  out  1  one-cycle pulse: backspace pressed.
- `keycode`  out  4  digit value 0–9 or operator code; valid while any pulse is high, holds its last value otherwise.
- `frame_err`  out  1  one-cycle pulse: frame discarded (bad stop bit, bad parity, or timeout).

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - A third flop on the synchronized clock gives falling-edge detect `fall` (sync value was 1, is now 0).
- Receiver FSM, sampling data only on `fall`:
  - IDLE: if `fall` and data=0 (start bit), go to RECEIVE with bit counter 0. If `fall` and data=1, stay in IDLE with no error.
  - RECEIVE: on each `fall`, shift data into an 8-bit register LSB first for counts 0–7. Count 8 captures parity. Count 9 captures the stop bit, then the FSM goes to CHECK.
  - CHECK (one cycle): the frame is valid iff stop=1 and parity makes the 9-bit data+parity odd. A valid frame goes to the decoder; an invalid one pulses `frame_err`. Either way, return to IDLE.
  - Timeout: a cycle counter clears on every `fall`. If it reaches `TIMEOUT_CYCLES` while in RECEIVE, pulse `frame_err`, return to IDLE, and clear the counter. No timeout applies in IDLE.
- Decoder, acting on valid bytes:
  - 0xF0 sets `brk` and produces no output.
  - 0xE0 is dropped, no output, and `brk` is unchanged. Extended keys therefore decode as their base code, so keypad Enter behaves as Enter.
  - Any other byte with `brk`=1 clears `brk` and produces no output.
  - Any other byte with `brk`=0 is decoded:
    - digits: 0x45→0, 0x16→1, 0x1E→2, 0x26→3, 0x25→4, 0x2E→5, 0x36→6, 0x3D→7, 0x3E→8, 0x46→9 → `dig_in`.
    - operators: 0x79 (+)→0, 0x7B (−)→1, 0x7C (×)→2, 0x5A (Enter/=)→3 → `op_in`.
    - 0x66 → `bksp_in`; `keycode` is unchanged.
    - anything else: no output, no error.
- At most one of `dig_in`/`op_in`/`bksp_in`/`frame_err` is high in any cycle.
- Typematic repeat (repeated make codes) produces one pulse per received make code; this is intended.

## Timing
- Reset values:
  - State IDLE, bit counter 0, timeout counter 0, `brk`=0, synchronizer flops 1.
  - All pulse outputs 0, `keycode`=0.
- Latency: let cycle N be the cycle in which `fall` samples the stop bit. CHECK occupies N+1. The output pulse (event or `frame_err`) is registered and is high only during cycle N+2.
- Input-to-`fall` delay is 3 `clock` cycles after a pad falling edge.
- Timeout `frame_err` is high the cycle after the counter reaches `TIMEOUT_CYCLES`.
- `reset` mid-frame aborts immediately: partial data and `brk` are lost, and no pulse is produced.
- `fall` arriving during CHECK is ignored. The PS/2 bit period of at least 60 µs makes this unreachable in normal use.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a parity failure in CHECK discards the frame and pulses `frame_err`.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is captured but ignored; only the stop bit and the timeout can cause `frame_err`.

## Test plan
- Frame 0x16 (parity 0, stop 1) → `dig_in` high for exactly 1 cycle at N+2, `keycode`=1; no other pulses.
- Sequence 0x79, 0xF0, 0x79 → exactly one `op_in` pulse with `keycode`=0; the break pair produces nothing, and `brk` is cleared afterwards.
- Sequence 0xE0, 0x5A → one `op_in` with `keycode`=3. Then 0x66 → `bksp_in` with `keycode` still 3.
- Frame 0x45 with the parity bit flipped:
  - with `PS2_PARITY_CHECK_EN` defined → `frame_err` pulse, no `dig_in`.
  - with it undefined → `dig_in`, `keycode`=0.
- Stop bit 0 on 0x25 → `frame_err`, no event. Then 5 bits of a frame followed by silence for `TIMEOUT_CYCLES` → `frame_err`. A following valid 0x3E → `dig_in`, `keycode`=8.
- Assert `reset` after 4 data bits of 0x46 → all outputs 0, FSM in IDLE. A complete 0x46 sent after release → `dig_in`, `keycode`=9.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pad pins and the key-event outputs of ps2_key_decoder.
// master: the decoder side; slave: the pad driver / event consumer side.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       dig_in;
  logic       op_in;
  logic       bksp_in;
  logic [3:0] keycode;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output dig_in, op_in, bksp_in, keycode, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  dig_in, op_in, bksp_in, keycode, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 receiver; turns make codes into calculator key pulses.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clock,
  input logic reset,
  ps2_key_decoder_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    CHECK
  } state_t;

  state_t state_q, state_d;

  logic ck_s1, ck_s2, ck_s3;
  logic dt_s1, dt_s2;
  logic fall;

  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          stop_q, stop_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          brk_q, brk_d;
  logic [3:0]    key_q, key_d;
  logic          dig_q, dig_d;
  logic          op_q, op_d;
  logic          bksp_q, bksp_d;
  logic          ferr_q, ferr_d;
  logic          ok;
  logic          tmo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ck_s1 <= 1'b1;
      ck_s2 <= 1'b1;
      ck_s3 <= 1'b1;
      dt_s1 <= 1'b1;
      dt_s2 <= 1'b1;
    end else begin
      ck_s1 <= bus.ps2_clk;
      ck_s2 <= ck_s1;
      ck_s3 <= ck_s2;
      dt_s1 <= bus.ps2_data;
      dt_s2 <= dt_s1;
    end
  end

  assign fall = ck_s3 & ~ck_s2;
  assign tmo  = (state_q == RECEIVE) && (tcnt_q == TW'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
  assign ok = stop_q & (^{sh_q, par_q});
`else
  logic unused_par;
  assign unused_par = par_q;
  assign ok = stop_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tcnt_q  <= '0;
      brk_q   <= 1'b0;
      key_q   <= '0;
      dig_q   <= 1'b0;
      op_q    <= 1'b0;
      bksp_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tcnt_q  <= tcnt_d;
      brk_q   <= brk_d;
      key_q   <= key_d;
      dig_q   <= dig_d;
      op_q    <= op_d;
      bksp_q  <= bksp_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    stop_d  = stop_q;
    brk_d   = brk_q;
    key_d   = key_q;
    dig_d   = 1'b0;
    op_d    = 1'b0;
    bksp_d  = 1'b0;
    ferr_d  = 1'b0;
    if (fall || state_q != RECEIVE)
      tcnt_d = '0;
    else
      tcnt_d = tcnt_q + TW'(1);

    unique case (state_q)
      IDLE: begin
        if (fall && !dt_s2) begin
          state_d = RECEIVE;
          cnt_d   = '0;
        end
      end
      RECEIVE: begin
        if (tmo) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
          tcnt_d  = '0;
        end else if (fall) begin
          if (cnt_q < 4'd8) begin
            sh_d  = {dt_s2, sh_q[7:1]};
            cnt_d = cnt_q + 4'd1;
          end else if (cnt_q == 4'd8) begin
            par_d = dt_s2;
            cnt_d = cnt_q + 4'd1;
          end else begin
            stop_d  = dt_s2;
            cnt_d   = '0;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!ok) begin
          ferr_d = 1'b1;
        end else if (sh_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (sh_q == 8'hE0) begin
          brk_d = brk_q;
        end else if (brk_q) begin
          brk_d = 1'b0;
        end else begin
          case (sh_q)
            8'h45: begin dig_d = 1'b1; key_d = 4'd0; end
            8'h16: begin dig_d = 1'b1; key_d = 4'd1; end
            8'h1E: begin dig_d = 1'b1; key_d = 4'd2; end
            8'h26: begin dig_d = 1'b1; key_d = 4'd3; end
            8'h25: begin dig_d = 1'b1; key_d = 4'd4; end
            8'h2E: begin dig_d = 1'b1; key_d = 4'd5; end
            8'h36: begin dig_d = 1'b1; key_d = 4'd6; end
            8'h3D: begin dig_d = 1'b1; key_d = 4'd7; end
            8'h3E: begin dig_d = 1'b1; key_d = 4'd8; end
            8'h46: begin dig_d = 1'b1; key_d = 4'd9; end
            8'h79: begin op_d = 1'b1; key_d = 4'd0; end
            8'h7B: begin op_d = 1'b1; key_d = 4'd1; end
            8'h7C: begin op_d = 1'b1; key_d = 4'd2; end
            8'h5A: begin op_d = 1'b1; key_d = 4'd3; end
            8'h66: bksp_d = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dig_in    = dig_q;
  assign bus.op_in     = op_q;
  assign bus.bksp_in   = bksp_q;
  assign bus.keycode   = key_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed PS/2 frame vectors and corner sequences for ps2_key_decoder.
module tb_ps2_key_decoder;
  localparam int TO = 300;

  logic clock = 1'b0;
  logic reset;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] code;
    bit         flip;
    bit         stop;
    logic [3:0] pulse;
    logic [3:0] key;
  } vec_t;

  vec_t vec[19];

  int checks = 0;
  int errors = 0;
  logic [3:0] p3, p4, p5, k4;

  function automatic logic [3:0] pulses();
    return {bus.dig_in, bus.op_in, bus.bksp_in, bus.frame_err};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && pulses() != 4'b0000) begin
      checks++;
      if ($countones(pulses()) > 1) begin
        errors++;
        $display("FAIL exclusive: got %b expected one-hot", pulses());
      end
    end
  end

  task automatic ps2_bit(bit d, bit capture);
    @(posedge clock);
    #2 bus.ps2_data = d;
    repeat (4) @(posedge clock);
    #2 bus.ps2_clk = 1'b0;
    if (capture) begin
      repeat (3) @(posedge clock);
      #1 p3 = pulses();
      @(posedge clock);
      #1 p4 = pulses();
      k4 = bus.keycode;
      @(posedge clock);
      #1 p5 = pulses();
      repeat (3) @(posedge clock);
    end else begin
      repeat (8) @(posedge clock);
    end
    #2 bus.ps2_clk = 1'b1;
    repeat (4) @(posedge clock);
  endtask

  task automatic send_frame(logic [7:0] b, bit flip, bit stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ flip, 1'b0);
    ps2_bit(stop, 1'b1);
  endtask

  task automatic run_vec(string name, vec_t v);
    send_frame(v.code, v.flip, v.stop);
    check({name, "_n1"}, 32'(p3), 32'(4'b0000));
    check({name, "_n2"}, 32'(p4), 32'(v.pulse));
    check({name, "_n3"}, 32'(p5), 32'(4'b0000));
    check({name, "_key"}, 32'(k4), 32'(v.key));
  endtask

  initial begin
    int found;
    logic [7:0] pb;

    vec[0]  = '{8'h16, 1'b0, 1'b1, 4'b1000, 4'd1};
    vec[1]  = '{8'h79, 1'b0, 1'b1, 4'b0100, 4'd0};
    vec[2]  = '{8'hF0, 1'b0, 1'b1, 4'b0000, 4'd0};
    vec[3]  = '{8'h79, 1'b0, 1'b1, 4'b0000, 4'd0};
    vec[4]  = '{8'h79, 1'b0, 1'b1, 4'b0100, 4'd0};
    vec[5]  = '{8'hE0, 1'b0, 1'b1, 4'b0000, 4'd0};
    vec[6]  = '{8'h5A, 1'b0, 1'b1, 4'b0100, 4'd3};
    vec[7]  = '{8'h66, 1'b0, 1'b1, 4'b0010, 4'd3};
`ifdef PS2_PARITY_CHECK_EN
    vec[8]  = '{8'h45, 1'b1, 1'b1, 4'b0001, 4'd3};
    vec[9]  = '{8'h25, 1'b0, 1'b0, 4'b0001, 4'd3};
`else
    vec[8]  = '{8'h45, 1'b1, 1'b1, 4'b1000, 4'd0};
    vec[9]  = '{8'h25, 1'b0, 1'b0, 4'b0001, 4'd0};
`endif
    vec[10] = '{8'h1E, 1'b0, 1'b1, 4'b1000, 4'd2};
    vec[11] = '{8'h7C, 1'b0, 1'b1, 4'b0100, 4'd2};
    vec[12] = '{8'h7B, 1'b0, 1'b1, 4'b0100, 4'd1};
    vec[13] = '{8'h12, 1'b0, 1'b1, 4'b0000, 4'd1};
    vec[14] = '{8'hF0, 1'b0, 1'b1, 4'b0000, 4'd1};
    vec[15] = '{8'h66, 1'b0, 1'b1, 4'b0000, 4'd1};
    vec[16] = '{8'h3D, 1'b0, 1'b1, 4'b1000, 4'd7};
    vec[17] = '{8'h66, 1'b0, 1'b1, 4'b0010, 4'd7};
    vec[18] = '{8'h46, 1'b0, 1'b1, 4'b1000, 4'd9};

    reset = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("rst_pulses", 32'(pulses()), 32'(4'b0000));
    check("rst_key", 32'(bus.keycode), 32'(4'd0));
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 19; i++) run_vec($sformatf("vec%0d", i), vec[i]);

    pb = 8'h25;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(pb[i], 1'b0);
    found = -1;
    for (int n = 13; n < TO + 60; n++) begin
      @(posedge clock);
      #1;
      if (found < 0 && bus.frame_err) found = n;
    end
    check("timeout_latency", 32'(found), 32'(TO + 4));
    run_vec("after_tmo", '{8'h3E, 1'b0, 1'b1, 4'b1000, 4'd8});

    send_frame(8'hF0, 1'b0, 1'b1);
    pb = 8'h46;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(pb[i], 1'b0);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 check("mid_rst_pulses", 32'(pulses()), 32'(4'b0000));
    check("mid_rst_key", 32'(bus.keycode), 32'(4'd0));
    check("mid_rst_state", 32'(dut.state_q), 32'(0));
    check("mid_rst_brk", 32'(dut.brk_q), 32'(0));
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    run_vec("after_rst", '{8'h46, 1'b0, 1'b1, 4'b1000, 4'd9});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
